// File: rtl/jt1943_romarb_if.sv
// jt1943_romarb_if: SDRAM request/response bus between the ROM arbiter and the memory controller
interface jt1943_romarb_if #(parameter int AW = 22);
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          data_rdy;
    logic [15:0]   sdram_dout;
    modport master (output sdram_req, sdram_addr, input sdram_ack, data_rdy, sdram_dout);
    modport slave  (input sdram_req, sdram_addr, output sdram_ack, data_rdy, sdram_dout);
endinterface

// File: rtl/jt1943_romarb.sv
// jt1943_romarb: three-way SDRAM fetch arbiter for obj/scroll/char ROMs
// JT1943_ROMARB_RR_EN selects round-robin grant; default is fixed priority obj > scr > chr
module jt1943_romarb #(
    parameter int         AW  = 22,
    parameter logic [7:0] TMO = 8'd64
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            obj_req,
    input  logic            scr_req,
    input  logic            chr_req,
    input  logic [AW-1:0]   obj_addr,
    input  logic [AW-1:0]   scr_addr,
    input  logic [AW-1:0]   chr_addr,
    output logic [15:0]     obj_data,
    output logic [15:0]     scr_data,
    output logic [15:0]     chr_data,
    output logic            obj_ok,
    output logic            scr_ok,
    output logic            chr_ok,
    jt1943_romarb_if.master sdram,
    output logic            tmo_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t             st;
    logic [2:0]         req, msk, ok;
    logic [2:0][AW-1:0] addr;
    logic [2:0][15:0]   data;
    logic [1:0]         gnt, sel;
    logic               excl;
    logic [7:0]         cnt;

    assign req  = {chr_req, scr_req, obj_req};
    assign addr = {chr_addr, scr_addr, obj_addr};
    assign {chr_data, scr_data, obj_data} = data;
    assign {chr_ok, scr_ok, obj_ok} = ok;
    // the requester just served sits out the first IDLE cycle after its ok
    assign msk  = req & ~({3{excl}} & (3'b1 << gnt));

`ifdef JT1943_ROMARB_RR_EN
    logic [1:0] ptr;
    function automatic logic [1:0] nxt(input logic [1:0] i);
        return i == 2'd2 ? 2'd0 : i + 2'd1;
    endfunction
    assign sel = msk[ptr] ? ptr : msk[nxt(ptr)] ? nxt(ptr) : nxt(nxt(ptr));
`else
    assign sel = msk[0] ? 2'd0 : msk[1] ? 2'd1 : 2'd2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st               <= IDLE;
            sdram.sdram_req  <= 1'b0;
            sdram.sdram_addr <= '0;
            ok               <= '0;
            tmo_err          <= 1'b0;
            data             <= '0;
            gnt              <= '0;
            excl             <= 1'b0;
            cnt              <= '0;
`ifdef JT1943_ROMARB_RR_EN
            ptr              <= '0;
`endif
        end else begin
            ok <= '0;
            case (st)
                IDLE: begin
                    excl <= 1'b0;
                    if (|msk) begin
                        gnt              <= sel;
                        sdram.sdram_addr <= addr[sel];
                        sdram.sdram_req  <= 1'b1;
                        st               <= ISSUE;
`ifdef JT1943_ROMARB_RR_EN
                        ptr              <= nxt(sel);
`endif
                    end
                end
                ISSUE: if (sdram.sdram_ack) begin
                    sdram.sdram_req <= 1'b0;
                    cnt             <= '0;
                    st              <= WAIT;
                end
                WAIT: begin
                    if (sdram.data_rdy) begin
                        data[gnt] <= sdram.sdram_dout;
                        ok        <= 3'b1 << gnt;
                        st        <= DONE;
                    end else if (cnt == TMO - 8'd1) begin
                        tmo_err <= 1'b1;
                        st      <= IDLE;
                    end else
                        cnt <= cnt + 8'd1;
                end
                default: begin
                    excl <= 1'b1;
                    st   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jt1943_romarb.sv
// tb_jt1943_romarb: vector table, corner-case sequences and randomized transactions against a grant model
module tb_jt1943_romarb;
    logic        clk = 0, rst = 1;
    logic [2:0]  rq = 0;
    logic [21:0] ad [3];
    logic [15:0] obj_data, scr_data, chr_data;
    logic        obj_ok, scr_ok, chr_ok, tmo_err;
    logic [2:0]  okv;
    int          checks = 0, errors = 0, cyc = 0;

    jt1943_romarb_if #(.AW(22)) sd();

    jt1943_romarb dut (
        .rst(rst), .clk(clk),
        .obj_req(rq[0]), .scr_req(rq[1]), .chr_req(rq[2]),
        .obj_addr(ad[0]), .scr_addr(ad[1]), .chr_addr(ad[2]),
        .obj_data(obj_data), .scr_data(scr_data), .chr_data(chr_data),
        .obj_ok(obj_ok), .scr_ok(scr_ok), .chr_ok(chr_ok),
        .sdram(sd), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign okv = {chr_ok, scr_ok, obj_ok};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (okv != 0) chk("ok_onehot", $countones(okv), 1);

    function automatic logic [15:0] dat(input int i);
        return i == 0 ? obj_data : i == 1 ? scr_data : chr_data;
    endfunction

    // grant model: candidates minus the last served one (when just served), falling back to all requesters
    function automatic int pick(input logic [2:0] r, input int last, input bit ex);
        logic [2:0] c = r;
        if (ex) c[last] = 1'b0;
        if (c == 0) c = r;
`ifdef JT1943_ROMARB_RR_EN
        for (int j = 1; j <= 3; j++) if (c[(last + j) % 3]) return (last + j) % 3;
`else
        for (int j = 0; j < 3; j++) if (c[j]) return j;
`endif
        return -1;
    endfunction

    task automatic wait_req();
        int w = 0;
        while (!sd.sdram_req && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("grant_wait", sd.sdram_req, 1);
    endtask

    task automatic serve(input int d, input int k, input logic [15:0] dv, input bit drop,
                         output int gi, output logic [21:0] ga, output int ic, output int oc);
        gi = -1; ga = 0; ic = 0; oc = 0;
        wait_req();
        if (!sd.sdram_req) return;
        ic = cyc;
        ga = sd.sdram_addr;
        if (drop) rq = 0;
        repeat (d) begin
            @(negedge clk);
            chk("issue_req_hold", sd.sdram_req, 1);
            chk("issue_addr_hold", sd.sdram_addr, ga);
        end
        sd.sdram_ack = 1;
        @(negedge clk);
        sd.sdram_ack = 0;
        chk("wait_req_low", sd.sdram_req, 0);
        repeat (k) @(negedge clk);
        sd.data_rdy = 1;
        sd.sdram_dout = dv;
        @(negedge clk);
        sd.data_rdy = 0;
        oc = cyc;
        gi = okv[0] ? 0 : okv[1] ? 1 : okv[2] ? 2 : -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; rq = 0; sd.sdram_ack = 0; sd.data_rdy = 0;
        @(negedge clk);
        rst = 0;
    endtask

    typedef struct {
        int          idx;
        logic [21:0] a;
        int          d;
        int          k;
        logic [15:0] dv;
        bit          drop;
        int          lat;
    } vec_t;

    initial begin
        vec_t        tv [6];
        int          gi, ic, oc, n, last, g, dd;
        logic [21:0] ga;
        logic [15:0] mdl [3];
        logic [15:0] dv;
        int          exp4 [4];
        tv[0] = '{0, 22'h01234, 0, 2, 16'hBEEF, 0, 5};
        tv[1] = '{1, 22'h2A5A5, 5, 0, 16'h1357, 0, 8};
        tv[2] = '{2, 22'h3FFFFF, 1, 3, 16'hCAFE, 0, 7};
        tv[3] = '{0, 22'h00001, 0, 1, 16'h0F0F, 1, 4};
        tv[4] = '{1, 22'h15555, 2, 4, 16'hA5A5, 1, 9};
        tv[5] = '{2, 22'h00000, 0, 0, 16'hFFFF, 0, 3};
`ifdef JT1943_ROMARB_RR_EN
        exp4 = '{0, 1, 2, 0};
`else
        exp4 = '{0, 1, 0, 1};
`endif
        sd.sdram_ack = 0; sd.data_rdy = 0; sd.sdram_dout = 0;
        for (int j = 0; j < 3; j++) ad[j] = 0;
        repeat (2) @(negedge clk);
        chk("rst_sdram_req", sd.sdram_req, 0);
        chk("rst_sdram_addr", sd.sdram_addr, 0);
        chk("rst_ok", okv, 0);
        chk("rst_tmo", tmo_err, 0);
        for (int j = 0; j < 3; j++) chk("rst_data", dat(j), 0);
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            repeat (2) @(negedge clk);
            chk("idle_no_ok", okv, 0);
            ad[tv[i].idx] = tv[i].a;
            rq[tv[i].idx] = 1;
            n = cyc;
            serve(tv[i].d, tv[i].k, tv[i].dv, tv[i].drop, gi, ga, ic, oc);
            rq = 0;
            chk("vec_grant", gi, tv[i].idx);
            chk("vec_addr", ga, tv[i].a);
            chk("vec_issue_lat", ic - n, 1);
            chk("vec_ok_lat", oc - n, tv[i].lat);
            chk("vec_data", dat(tv[i].idx), tv[i].dv);
        end

        // a lone requester held high is regranted only after one skipped IDLE cycle
        repeat (2) @(negedge clk);
        ad[0] = 22'h0ABCD;
        rq[0] = 1;
        serve(0, 0, 16'h1111, 0, gi, ga, ic, oc);
        n = oc;
        serve(0, 0, 16'h2222, 0, gi, ga, ic, oc);
        rq = 0;
        chk("regrant_gap", ic - n, 3);
        chk("regrant_idx", gi, 0);

        do_reset();
        rq = 3'b111;
        for (int t = 0; t < 4; t++) begin
            serve(0, 0, 16'h4000 + 16'(t), 0, gi, ga, ic, oc);
            chk("all_held_grant", gi, exp4[t]);
        end
        rq = 0;

        do_reset();
        ad[1] = 22'h12345;
        rq[1] = 1;
        serve(0, 1, 16'h5A5A, 0, gi, ga, ic, oc);
        rq = 0;
        chk("tmo_pre_grant", gi, 1);
        repeat (2) @(negedge clk);
        rq[1] = 1;
        wait_req();
        sd.sdram_ack = 1;
        @(negedge clk);
        sd.sdram_ack = 0;
        rq = 0;
        for (int j = 0; j < 63; j++) begin
            chk("tmo_wait_ok", okv, 0);
            @(negedge clk);
        end
        chk("tmo_early", tmo_err, 0);
        @(negedge clk);
        chk("tmo_set", tmo_err, 1);
        chk("tmo_req_low", sd.sdram_req, 0);
        chk("tmo_no_ok", okv, 0);
        sd.data_rdy = 1;
        sd.sdram_dout = 16'hFFFF;
        @(negedge clk);
        sd.data_rdy = 0;
        chk("tmo_data_kept", scr_data, 16'h5A5A);
        chk("tmo_late_rdy_ok", okv, 0);
        rq[0] = 1;
        @(negedge clk);
        chk("tmo_back_idle", sd.sdram_req, 1);
        serve(0, 0, 16'h7777, 0, gi, ga, ic, oc);
        rq = 0;
        chk("tmo_after_grant", gi, 0);
        chk("tmo_sticky", tmo_err, 1);

        repeat (2) @(negedge clk);
        rq[2] = 1;
        wait_req();
        sd.sdram_ack = 1;
        @(negedge clk);
        sd.sdram_ack = 0;
        rq = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mrst_tmo", tmo_err, 0);
        sd.data_rdy = 1;
        sd.sdram_dout = 16'h1234;
        @(negedge clk);
        sd.data_rdy = 0;
        sd.sdram_ack = 1;
        for (int j = 0; j < 4; j++) begin
            chk("mrst_no_ok", okv, 0);
            chk("mrst_req_low", sd.sdram_req, 0);
            @(negedge clk);
            sd.sdram_ack = 0;
        end
        for (int j = 0; j < 3; j++) chk("mrst_data", dat(j), 0);

        do_reset();
        last = 2;
        dd = 0;
        for (int j = 0; j < 3; j++) mdl[j] = 0;
        for (int t = 0; t < 40; t++) begin
            rq = 3'($urandom_range(1, 7));
            for (int j = 0; j < 3; j++) ad[j] = 22'($urandom);
            g = pick(rq, last, dd != 0);
            dv = 16'($urandom);
            serve($urandom_range(0, 3), $urandom_range(0, 5), dv, 1'($urandom_range(0, 1)), gi, ga, ic, oc);
            chk("rnd_grant", gi, g);
            chk("rnd_addr", ga, ad[g]);
            mdl[g] = dv;
            for (int j = 0; j < 3; j++) chk("rnd_data", dat(j), mdl[j]);
            last = g;
            dd = 1;
        end
        rq = 0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/jt1943_romarb.md
JT1943_ROMARB -- requirements
Module: jt1943_romarb

Interface
REQ-001 Parameter AW, 22, SDRAM word-address width.
REQ-002 Parameter TMO, 8'd64, maximum cycles allowed in WAIT before the request is abandoned.
REQ-003 Port rst  input  1  synchronous reset, active-high.
REQ-004 Port clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port obj_req, scr_req, chr_req  input  1 each  level fetch request, obj/scroll/char requesters (index 0/1/2).
REQ-006 Port obj_addr, scr_addr, chr_addr  input  AW each  word address, held stable while the matching req is high.
REQ-007 Port obj_data, scr_data, chr_data  output  16 each  last word fetched for that requester.
REQ-008 Port obj_ok, scr_ok, chr_ok  output  1 each  one-cycle pulse: the matching data output was updated this cycle.
REQ-009 Port sdram_req  output  1  request to the SDRAM controller.
REQ-010 Port sdram_addr  output  AW  address presented with sdram_req.
REQ-011 Port sdram_ack  input  1  the controller accepted the request.
REQ-012 Port data_rdy  input  1  sdram_dout is valid this cycle.
REQ-013 Port sdram_dout  input  16  SDRAM read data.
REQ-014 Port tmo_err  output  1  sticky flag set on any timeout; cleared only by rst.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-016 In IDLE, when any req is high, the FSM SHALL latch the grant index and that requester's address, then move to ISSUE on the next cycle.
REQ-017 In ISSUE, sdram_req SHALL be 1 and sdram_addr SHALL equal the latched address; the FSM SHALL stay in ISSUE until sdram_ack=1, then move to WAIT.
REQ-018 In WAIT, sdram_req SHALL be 0; on data_rdy=1, sdram_dout SHALL be latched into the granted data register and the FSM SHALL move to DONE.
REQ-019 In DONE, the granted ok SHALL be 1 for exactly that cycle; the FSM SHALL then return to IDLE.
REQ-020 Latency from req rising in IDLE (cycle N) with sdram_ack same-cycle and data_rdy k cycles later: ok SHALL pulse at cycle N+3+k.
REQ-021 A requester SHALL NOT be regranted in the IDLE cycle immediately after its ok pulse; its req SHALL be sampled again from the following cycle onwards.
REQ-022 data_rdy outside WAIT SHALL be ignored; sdram_ack outside ISSUE SHALL be ignored.
REQ-023 A requester dropping req after grant SHALL NOT abort the transaction; the fetched data SHALL still be delivered with an ok pulse.
REQ-024 A WAIT counter SHALL start at 0 on WAIT entry; on reaching TMO-1 without data_rdy, the FSM SHALL set tmo_err, skip ok, return to IDLE, and leave the data register unchanged.
REQ-025 At most one ok output SHALL be high in any cycle.
REQ-026 sdram_addr SHALL hold its last value outside ISSUE.

Reset
REQ-027 On rst=1, the FSM SHALL enter IDLE; sdram_req, all ok outputs and tmo_err SHALL be 0; data registers SHALL be 16'h0; sdram_addr SHALL be 0; the round-robin pointer SHALL select obj.
REQ-028 rst asserted in ISSUE or WAIT SHALL abandon the transaction without an ok pulse; a data_rdy arriving after reset release SHALL be ignored.

Configuration
REQ-029 Macro JT1943_ROMARB_RR_EN defined: the IDLE grant SHALL be round-robin, searching starting from the index after the last granted one (obj->scr->chr->obj).
REQ-030 Macro JT1943_ROMARB_RR_EN undefined: the IDLE grant SHALL be fixed priority obj > scr > chr; REQ-021 still applies.

Verification
REQ-031 Single request: obj_req=1, obj_addr=22'h01234, ack same cycle, data_rdy 2 cycles later with dout=16'hBEEF -> sdram_addr=22'h01234 in ISSUE; obj_data=16'hBEEF; obj_ok pulses once at N+5.
REQ-032 All three req held high, RR_EN defined -> grants in order obj, scr, chr, obj; the same index is never granted twice in a row.
REQ-033 All three req held high, RR_EN undefined -> grants alternate obj, scr, obj, scr; chr is granted only when obj and scr are low.
REQ-034 Timeout: grant scr, ack, no data_rdy for 64 cycles -> tmo_err=1; no scr_ok; FSM in IDLE; scr_data unchanged.
REQ-035 Reset mid-WAIT: rst for 1 cycle during WAIT, then data_rdy -> no ok pulse; sdram_req=0; all data registers=0.
REQ-036 Delayed ack: ack held low 5 cycles in ISSUE -> sdram_req and sdram_addr stay stable for all 5 cycles; transaction completes normally afterwards.
